// File: rtl/des_key_pkg.sv
// Shared DES key-schedule definitions: widths, PC-1/PC-2 tables, rotation schedule,
// sequencer state encoding and the round-key payload type.
package des_key_pkg;

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned PC1_W  = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned ROUNDS = 16;
  localparam int unsigned IDX_W  = 4;

  // Bit r-1 set means round r rotates C and D left by two places instead of one.
  localparam logic [ROUNDS-1:0] SHIFT2_MASK_DEFAULT = 16'b0111_1110_1111_1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [RK_W-1:0]  key;
  } round_key_t;

  // Entries are DES bit numbers (1 = MSB of the source vector).
  localparam int unsigned PC1_TABLE [PC1_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TABLE [RK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] x,
                                                  input logic            by2);
    return by2 ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
               : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

endpackage

// File: rtl/permutation_choice1.sv
// DES Permuted Choice 1: drops the eight parity bits and reorders the key into C||D.
module permutation_choice1
  import des_key_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  output logic [PC1_W-1:0] cd_out
);

  for (genvar i = 0; i < PC1_W; i++) begin : g_bit
    assign cd_out[PC1_W-1-i] = key_in[KEY_W - PC1_TABLE[i]];
  end

  // Parity bits (DES bits 8, 16, ..., 64) carry no key material.
  logic parity_unused;
  assign parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

endmodule

// File: rtl/permutation_choice2.sv
// DES Permuted Choice 2: compresses the 56-bit C||D into a 48-bit round key.
module permutation_choice2
  import des_key_pkg::*;
(
  input  logic [PC1_W-1:0] cd_in,
  output logic [RK_W-1:0]  rk_out
);

  for (genvar i = 0; i < RK_W; i++) begin : g_bit
    assign rk_out[RK_W-1-i] = cd_in[PC1_W - PC2_TABLE[i]];
  end

  // Eight C||D positions (DES bits 9, 18, 22, 25, 35, 38, 43, 54) are never selected.
  logic dropped_unused;
  assign dropped_unused = ^{cd_in[47], cd_in[38], cd_in[34], cd_in[31],
                            cd_in[21], cd_in[18], cd_in[13], cd_in[2]};

endmodule

// File: rtl/key_schedule_sequencer.sv
// Generates the 16 DES round keys one per cycle from an accepted key, streams them
// out and keeps them in a readable 16-entry register store.
module key_schedule_sequencer
  import des_key_pkg::*;
#(
  parameter logic [ROUNDS-1:0] SHIFT2_MASK = SHIFT2_MASK_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              rk_valid,
  output logic [IDX_W-1:0]  rk_index,
  output logic [RK_W-1:0]   rk_out,
  output logic              keys_ready,
  output logic              sched_done,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [RK_W-1:0]   rd_key
);

  sched_state_e      state;
  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic [HALF_W-1:0] c_shift;
  logic [HALF_W-1:0] d_shift;
  logic [IDX_W-1:0]  round_q;
  logic [PC1_W-1:0]  pc1_key;
  logic [RK_W-1:0]   rk_next;
  logic [RK_W-1:0]   store [ROUNDS];
  round_key_t        rk_q;
  logic              rk_valid_q;
  logic              keys_ready_q;
  logic              sched_done_q;
  logic              key_ready_q;
  logic              last_round;

  permutation_choice1 u_pc1 (
    .key_in (key_in),
    .cd_out (pc1_key)
  );

  // Round r uses the halves after this round's rotation, so PC-2 sees the shifted value.
  assign c_shift    = rotl_half(c_q, SHIFT2_MASK[round_q]);
  assign d_shift    = rotl_half(d_q, SHIFT2_MASK[round_q]);
  assign last_round = (round_q == IDX_W'(ROUNDS - 1));

  permutation_choice2 u_pc2 (
    .cd_in  ({c_shift, d_shift}),
    .rk_out (rk_next)
  );

  // Sequencer, key halves, output registers and round-key store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      c_q          <= '0;
      d_q          <= '0;
      round_q      <= '0;
      rk_q         <= '0;
      rk_valid_q   <= 1'b0;
      keys_ready_q <= 1'b0;
      sched_done_q <= 1'b0;
      key_ready_q  <= 1'b1;
      for (int unsigned i = 0; i < ROUNDS; i++) begin
        store[i] <= '0;
      end
    end else begin
      rk_valid_q   <= 1'b0;
      sched_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key_valid) begin
            {c_q, d_q}   <= pc1_key;
            round_q      <= '0;
            keys_ready_q <= 1'b0;
            key_ready_q  <= 1'b0;
            state        <= ST_GEN;
          end
        end
        ST_GEN: begin
          c_q             <= c_shift;
          d_q             <= d_shift;
          store[round_q]  <= rk_next;
          rk_q.key        <= rk_next;
          rk_q.index      <= round_q;
          rk_valid_q      <= 1'b1;
          if (last_round) begin
            round_q      <= '0;
            keys_ready_q <= 1'b1;
            sched_done_q <= 1'b1;
            key_ready_q  <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            round_q <= round_q + IDX_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          key_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign key_ready  = key_ready_q;
  assign rk_valid   = rk_valid_q;
  assign rk_index   = rk_q.index;
  assign rk_out     = rk_q.key;
  assign keys_ready = keys_ready_q;
  assign sched_done = sched_done_q;
  assign rd_key     = store[rd_addr];

endmodule

// File: tb/tb_key_schedule_sequencer.sv
// Self-checking bench for key_schedule_sequencer against a behavioural DES key-schedule model.
module tb_key_schedule_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        key_valid;
  logic        key_ready;
  logic        rk_valid;
  logic [3:0]  rk_index;
  logic [47:0] rk_out;
  logic        keys_ready;
  logic        sched_done;
  logic [3:0]  rd_addr;
  logic [47:0] rd_key;

  int n_vec = 0;
  int n_err = 0;

  key_schedule_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_valid   (rk_valid),
    .rk_index   (rk_index),
    .rk_out     (rk_out),
    .keys_ready (keys_ready),
    .sched_done (sched_done),
    .rd_addr    (rd_addr),
    .rd_key     (rd_key)
  );

  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: textbook DES key schedule
  int pc1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                   60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                   29,21,13,5,28,20,12,4};
  int pc2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int rot [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic [47:0] exp_rk [16];
  logic [47:0] cap_rk [16];

  task automatic model_keys(input logic [63:0] key);
    logic [55:0] cd;
    logic [63:0] tk;
    logic [55:0] tcd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] rk;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      tk = key >> (64 - pc1[i]);
      cd = {cd[54:0], tk[0]};
    end
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = 28'((c << rot[r]) | (c >> (28 - rot[r])));
      d = 28'((d << rot[r]) | (d >> (28 - rot[r])));
      rk = '0;
      for (int i = 0; i < 48; i++) begin
        tcd = {c, d} >> (56 - pc2[i]);
        rk = {rk[46:0], tcd[0]};
      end
      exp_rk[r] = rk;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Checks the 16-cycle stream following an acceptance edge; caller is at posedge+1 after E0.
  task automatic check_stream(input logic hold_next);
    int strobes;
    strobes = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (rk_valid === 1'b1) strobes++;
      cap_rk[i] = rk_out;
      chk("rk_valid", 64'(rk_valid), 64'(1));
      chk("rk_index", 64'(rk_index), 64'(i));
      chk("rk_out", 64'(rk_out), 64'(exp_rk[i]));
      chk("sched_done", 64'(sched_done), 64'(i == 15));
      chk("keys_ready_gen", 64'(keys_ready), 64'(i == 15));
      chk("key_ready_gen", 64'(key_ready), 64'(i == 15));
      rd_addr = 4'(i);
      #1;
      chk("rd_key_raw", 64'(rd_key), 64'(exp_rk[i]));
    end
    if (!hold_next) begin
      @(posedge clk); #1;
      if (rk_valid === 1'b1) strobes++;
      chk("rk_valid_after", 64'(rk_valid), 64'(0));
      chk("sched_done_after", 64'(sched_done), 64'(0));
      chk("keys_ready_after", 64'(keys_ready), 64'(1));
      chk("key_ready_after", 64'(key_ready), 64'(1));
      @(posedge clk); #1;
      if (rk_valid === 1'b1) strobes++;
      chk("strobe_count", 64'(strobes), 64'(16));
    end
  endtask

  task automatic run_key(input logic [63:0] key);
    model_keys(key);
    chk("key_ready_idle", 64'(key_ready), 64'(1));
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_in    = {$urandom, $urandom};
    chk("keys_ready_e0", 64'(keys_ready), 64'(0));
    check_stream(1'b0);
  endtask

  typedef struct {
    logic [63:0] key;
    logic [3:0]  idx;
    logic [47:0] rk;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [63:0] k1;
    logic [63:0] k2;
    logic [47:0] k1_rk [16];

    vecs[0] = '{64'h133457799BBCDFF1, 4'd0,  48'h1B02EFFC7072};
    vecs[1] = '{64'h133457799BBCDFF1, 4'd15, 48'hCB3D8B0E17F5};
    vecs[2] = '{64'h0000000000000000, 4'd0,  48'h000000000000};
    vecs[3] = '{64'h0000000000000000, 4'd9,  48'h000000000000};
    vecs[4] = '{64'h0000000000000000, 4'd15, 48'h000000000000};
    vecs[5] = '{64'hFFFFFFFFFFFFFFFF, 4'd0,  48'hFFFFFFFFFFFF};
    vecs[6] = '{64'hFFFFFFFFFFFFFFFF, 4'd7,  48'hFFFFFFFFFFFF};
    vecs[7] = '{64'hFFFFFFFFFFFFFFFF, 4'd15, 48'hFFFFFFFFFFFF};

    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rd_addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", 64'(key_ready), 64'(1));
    chk("rst_rk_valid", 64'(rk_valid), 64'(0));
    chk("rst_rk_out", 64'(rk_out), 64'(0));
    chk("rst_keys_ready", 64'(keys_ready), 64'(0));
    chk("rst_sched_done", 64'(sched_done), 64'(0));
    rst = 1'b0;

    // Table vectors: known answers through both the stream and the store.
    for (int v = 0; v < 8; v++) begin
      run_key(vecs[v].key);
      chk("tbl_stream", 64'(cap_rk[vecs[v].idx]), 64'(vecs[v].rk));
      rd_addr = vecs[v].idx;
      #1;
      chk("tbl_rd_key", 64'(rd_key), 64'(vecs[v].rk));
      chk("tbl_keys_ready", 64'(keys_ready), 64'(1));
    end

    // key_valid held through GEN with a different key; accepted right after E16.
    k1 = {$urandom, $urandom};
    k2 = {$urandom, $urandom};
    model_keys(k1);
    for (int i = 0; i < 16; i++) k1_rk[i] = exp_rk[i];
    key_in    = k1;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_in = k2;
    check_stream(1'b1);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk("hold_store_first", 64'(rd_key), 64'(k1_rk[i]));
    end
    model_keys(k2);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("b2b_keys_ready", 64'(keys_ready), 64'(0));
    chk("b2b_key_ready", 64'(key_ready), 64'(0));
    chk("b2b_rk_valid", 64'(rk_valid), 64'(0));
    check_stream(1'b0);

    // Reset in the middle of round generation.
    model_keys(64'h0123456789ABCDEF);
    key_in    = 64'h0123456789ABCDEF;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_index", 64'(rk_index), 64'(6));
    rst = 1'b1;
    #1;
    chk("midrst_rk_valid", 64'(rk_valid), 64'(0));
    chk("midrst_rk_index", 64'(rk_index), 64'(0));
    chk("midrst_rk_out", 64'(rk_out), 64'(0));
    chk("midrst_key_ready", 64'(key_ready), 64'(1));
    @(posedge clk); #1;
    chk("midrst_keys_ready", 64'(keys_ready), 64'(0));
    chk("midrst_sched_done", 64'(sched_done), 64'(0));
    chk("midrst_rk_valid2", 64'(rk_valid), 64'(0));
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk("midrst_rd_key", 64'(rd_key), 64'(0));
    end
    rst = 1'b0;
    run_key({$urandom, $urandom});

    // Random keys against the model.
    for (int n = 0; n < 8; n++) begin
      run_key({$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
